// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: the hex glyph table, the blank code and the
// anode-select helper used by the capture logic and the decoder.
package ssd_pkg;

  localparam int SEG_W = 7;
  localparam int AN_W  = 4;
  localparam int RUN_W = 8;
  localparam int AGE_W = 20;

  // Active-low segments, bit6 = a .. bit0 = g
  localparam logic [SEG_W-1:0] BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } an_sel_t;

  // The single table both directions are built from.
  function automatic logic [SEG_W-1:0] encode(input logic [3:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  // Only a single low anode addresses a digit; anything else is not a capture.
  function automatic an_sel_t an_select(input logic [AN_W-1:0] an);
    an_sel_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (an)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ssd_decode.sv
// Combinational inverse of ssd_pkg::encode: exact table match to a hex value,
// with a separate flag for the all-off blank pattern.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             hit_o,
  output logic             blank_o,
  output logic [3:0]       value_o
);

  always_comb begin
    hit_o   = 1'b0;
    value_o = 4'h0;
    blank_o = (seg_i == BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_i == encode(4'(i))) begin
        hit_o   = 1'b1;
        value_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ssd_capture4.sv
// Recovers four hex digits from a multiplexed active-low seven-segment bus by
// sampling each anode/segment pattern once it has been stable long enough.
module ssd_capture4
  import ssd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 524288
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] abcdefg,
  input  logic [AN_W-1:0]  an,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       mode,
  output logic [3:0]       valid,
  output logic             err,
  output logic             frame
);

  localparam logic [RUN_W-1:0] STABLE_W  = RUN_W'(STABLE_CYCLES);
  localparam logic [AGE_W-1:0] TIMEOUT_W = AGE_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX   = {RUN_W{1'b1}};

  logic [AN_W-1:0]        an_q;
  logic [SEG_W-1:0]       seg_q;
  logic [AN_W+SEG_W-1:0]  prev_q;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [3:0][3:0]        digit_q, digit_d;
  logic [3:0]             mode_q, mode_d;
  logic [3:0]             valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   frame_q, frame_d;
  logic [3:0]             seen_q, seen_d;
  logic [3:0][AGE_W-1:0]  age_q, age_d;

  logic                   changed;
  logic                   fire;
  an_sel_t                sel;
  logic [3:0]             cap_mask;
  logic                   dec_hit, dec_blank;
  logic [3:0]             dec_value;

  ssd_decode u_decode (
    .seg_i   (seg_q),
    .hit_o   (dec_hit),
    .blank_o (dec_blank),
    .value_o (dec_value)
  );

  // The run counter value for the current cycle; it restarts on any change of
  // the registered pins and saturates so long idle periods cannot wrap.
  always_comb begin
    changed = ({an_q, seg_q} != prev_q);
    if (changed)
      run_d = RUN_W'(1);
    else if (run_q == RUN_MAX)
      run_d = RUN_MAX;
    else
      run_d = run_q + RUN_W'(1);
  end

  // Guard against refiring while saturated when STABLE_CYCLES is the maximum.
  assign fire     = (run_d == STABLE_W) && (changed || (run_q != STABLE_W));
  assign sel      = an_select(an_q);
  assign cap_mask = (fire && sel.ok) ? (4'b0001 << sel.idx) : 4'b0000;

  always_comb begin
    digit_d = digit_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    age_d   = age_q;
    err_d   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) begin
        age_d[i] = '0;
        if (dec_hit) begin
          digit_d[i] = dec_value;
          mode_d[i]  = 1'b1;
          valid_d[i] = 1'b1;
        end else if (dec_blank) begin
          mode_d[i]  = 1'b0;
          valid_d[i] = 1'b1;
        end else begin
          valid_d[i] = 1'b0;
          err_d      = 1'b1;
        end
      end else if (age_q[i] != TIMEOUT_W) begin
        age_d[i] = age_q[i] + AGE_W'(1);
        if (age_d[i] == TIMEOUT_W)
          valid_d[i] = 1'b0;
      end
    end
  end

  // A full mask is reported one cycle later; captures in that cycle start the
  // next frame instead of being lost.
  always_comb begin
    frame_d = &seen_q;
    seen_d  = ((&seen_q) ? 4'b0000 : seen_q) | cap_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= 4'b1111;
      seg_q   <= BLANK;
      prev_q  <= {4'b1111, BLANK};
      run_q   <= RUN_W'(1);
      digit_q <= '0;
      mode_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
      seen_q  <= '0;
      age_q   <= '0;
    end else begin
      an_q    <= an;
      seg_q   <= abcdefg;
      prev_q  <= {an_q, seg_q};
      run_q   <= run_d;
      digit_q <= digit_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      seen_q  <= seen_d;
      age_q   <= age_d;
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
  assign mode   = mode_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign frame  = frame_q;

endmodule
